fetch_instr_queue: RTL
======================

Name: fetch_instr_queue

Overview:
- Decoupling FIFO between the instruction fetch unit (F stage) and the dual-issue decoder (D stage).
- Accepts 0–2 instructions per cycle from F, splitting each 64-bit fetch pair into per-instruction entries in program order.
- Presents up to 2 oldest entries per cycle to D.
- Whole-queue flush on any redirect (exception, eret, branch mispredict, icache-instruction refetch).

Parameters:
- DEPTH, 8, number of instruction entries; power of 2, minimum 4.
- BP_W, 40, width of the flattened branch-prediction record carried per instruction.

Ports:
- clk  input  1  clock
- resetn  input  1  asynchronous active-low reset
- flush  input  1  redirect; drop all stored and incoming instructions this cycle
- valid_F  input  2  per-slot valid from F; legal patterns 00/01/10/11
- instr_F  input  64  slot0 = [31:0], slot1 = [63:32]
- pc_F  input  32  8-byte-aligned pair base; slot0 pc = pc_F, slot1 pc = {pc_F[31:3],1'b1,pc_F[1:0]}
- exc_code_F  input  5  fetch exception code, shared by both slots
- tre_F  input  1  TLB refill flag, shared by both slots
- bp_info_F  input  2*BP_W  per-slot prediction record; slot i = [i*BP_W +: BP_W]
- allowin_D  output  1  queue can take a full pair this cycle
- valid_D  output  2  head entries valid; [0] oldest
- instr_D  output  64  slot0 = [31:0], slot1 = [63:32]
- pc_D  output  64  slot0 = [31:0], slot1 = [63:32]
- exc_code_D  output  10  5 bits per slot
- tre_D  output  2  one bit per slot
- bp_info_D  output  2*BP_W  per-slot prediction record
- deq_D  input  2  number of presented entries D consumes: 0, 1 or 2; must not exceed popcount(valid_D)
- count  output  $clog2(DEPTH)+1  current occupancy, for debug and perf counters

Behaviour:
- Storage: DEPTH-entry circular buffer. Each entry holds {pc, instr, exc_code, tre, bp}.
- Pointers: head and tail, each $clog2(DEPTH)+1 bits with a wrap bit. count = tail - head. Full when count == DEPTH; empty when count == 0.
- allowin_D = (count <= DEPTH-2).
  - Uses pre-dequeue occupancy, so it is conservative.
  - Is independent of deq_D, which avoids a combinational path D→F.
- Enqueue: fires when allowin_D && !flush && |valid_F.
  - Writes only the valid slots, slot0 first, at tail and tail+1.
  - tail advances by popcount(valid_F).
  - A slot-1-only pattern (10) writes one entry at tail carrying the slot1 pc.
- Per-slot fields at enqueue:
  - exc_code and tre are copied to every written entry.
  - bp takes the slot's own BP_W field.
- valid_F while allowin_D is low is a protocol violation by F. The queue ignores the data, and an assertion must fire.
- Dequeue:
  - valid_D[0] = (count >= 1); valid_D[1] = (count >= 2).
  - Output fields come from entries head and head+1.
  - Fields of invalid slots are driven to 0.
  - head advances by deq_D.
- Simultaneous enqueue and dequeue: both apply in the same cycle; count_next = count + popcount(enq) - deq_D.
- Exceptions: an entry with nonzero exc_code is presented like any other entry. D stops consuming after it; the queue needs no special casing.
- Latency: an instruction enqueued in cycle N is visible on valid_D in cycle N+1 (base build).
- flush:
  - head and tail reset to 0 at the next edge.
  - Enqueue is suppressed in the flush cycle.
  - deq_D in the flush cycle is ignored.
  - valid_D is not masked in the flush cycle; D already squashes on the same redirect.
- Wrap-around: pointer arithmetic is modulo 2*DEPTH; entry index = pointer[$clog2(DEPTH)-1:0]. A pair may straddle index DEPTH-1 → 0.
- Reset (async, resetn low):
  - head = tail = 0, so count = 0, valid_D = 00 and all data outputs = 0.
  - allowin_D = 1 immediately.
  - Entry storage is not reset.
  - Reset mid-operation discards all contents.

Optional Feature:
- Macro: FIQ_BYPASS_EN.
- Defined: when count == 0 and an enqueue fires, the incoming slots drive valid_D and data combinationally in the same cycle (zero latency).
  - Entries that D consumes through deq_D are not stored; the rest are written normally.
  - With count == 1, slot1 of the output may be taken from F slot0.
  - Bypass is disabled in a flush cycle.
- Undefined: 1-cycle latency as in the base build. Outputs depend only on registered state.

Test Plan:
- Reset then fill: resetn low→high; F sends valid_F=11, pc_F=0xBFC00000 for 4 cycles, deq_D=0 → count 2,4,6,8; allowin_D goes 0 once count is 8 (DEPTH=8); head pcs on valid_D are 0xBFC00000 and 0xBFC00004.
- Odd patterns: valid_F=10 at pc_F=0x80000008, then 01 at 0x80000010 → entries pc 0x8000000C then 0x80000010; valid_D=11.
- Simultaneous traffic: count=6, enqueue 11 and deq_D=2 in the same cycle → count stays 6; allowin_D=1 (6 <= 6); FIFO order preserved across the index 7→0 wrap.
- Flush mid-stream: count=5, flush=1 together with valid_F=11 → next cycle count=0, valid_D=00, nothing enqueued.
- Exception passthrough: exc_code_F=TLBL, tre_F=1, valid_F=11 → both entries show exc_code 5'h02 and tre 1; bp_info_D slots match their input fields.
- FIQ_BYPASS_EN: queue empty, valid_F=11, deq_D=2 → valid_D=11 in the same cycle and count remains 0; without the macro, valid_D=00 that cycle and 11 the next.

Source files
------------

// File: rtl/fetch_instr_queue.sv
// -----------------------------------------------------------------------------
// fetch_instr_queue
//   Decoupling FIFO between the instruction fetch stage (F) and the dual-issue
//   decoder (D). Each cycle F may push 0-2 instructions from an aligned 64-bit
//   fetch pair; they are split into per-instruction entries in program order.
//   D is shown the two oldest entries and consumes 0-2 of them. A redirect
//   (flush) empties the whole queue.
//
//   Optional build macro: FIQ_BYPASS_EN
//     Undefined (default): one-cycle latency, outputs come only from storage.
//     Defined: when the queue is empty (or holds one entry) and a pair is
//     accepted, the incoming instructions are presented to D in the same cycle.
//
// Ports
//   clk, resetn       clock, asynchronous active-low reset
//   flush             redirect: drop stored and incoming instructions
//   valid_F[1:0]      per-slot valid from F (slot0 is older)
//   instr_F[63:0]     slot0 = [31:0], slot1 = [63:32]
//   pc_F[31:0]        8-byte aligned pair base address
//   exc_code_F, tre_F fetch exception code / TLB-refill flag for both slots
//   bp_info_F         per-slot branch prediction records
//   allowin_D         queue can take a full pair this cycle
//   valid_D[1:0]      head entries valid, [0] oldest
//   instr_D, pc_D, exc_code_D, tre_D, bp_info_D   per-slot head fields
//   deq_D[1:0]        number of presented entries D consumes this cycle
//   count             current occupancy
//
// Handshake: F -> queue, a slot transfers when valid_F[i] && allowin_D && !flush;
// allowin_D depends only on registered occupancy, so F may look at it before
// deciding to drive valid_F. Queue -> D, valid_D marks presented entries and
// deq_D (never more than the number presented) removes that many from the head.
// -----------------------------------------------------------------------------
module fetch_instr_queue #(
   parameter int DEPTH = 8,
   parameter int BP_W  = 40
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    flush,
   input  logic [1:0]              valid_F,
   input  logic [63:0]             instr_F,
   input  logic [31:0]             pc_F,
   input  logic [4:0]              exc_code_F,
   input  logic                    tre_F,
   input  logic [2*BP_W-1:0]       bp_info_F,
   output logic                    allowin_D,
   output logic [1:0]              valid_D,
   output logic [63:0]             instr_D,
   output logic [63:0]             pc_D,
   output logic [9:0]              exc_code_D,
   output logic [1:0]              tre_D,
   output logic [2*BP_W-1:0]       bp_info_D,
   input  logic [1:0]              deq_D,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] ALLOW_MAX = PW'(DEPTH - 2);

   typedef struct packed {
      logic [31:0]     pc;
      logic [31:0]     instr;
      logic [4:0]      exc;
      logic            tre;
      logic [BP_W-1:0] bp;
   } entry_t;

   // Pointers carry a wrap bit so full (count == DEPTH) and empty differ.
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [PW-1:0] count_w;

   entry_t        mem_q [DEPTH];

   entry_t        slot0_e, slot1_e;
   entry_t        in_a, in_b;
   logic [1:0]    enq_num;
   logic          enq_fire;

   logic          wr0_en, wr1_en;
   logic [AW-1:0] wr_idx0, wr_idx1;
   logic [AW-1:0] rd_idx0, rd_idx1;
   entry_t        rd0, rd1;

   logic          v0, v1;
   entry_t        view0, view1;

   assign count_w   = tail_q - head_q;
   assign count     = count_w;
   // Pre-dequeue occupancy keeps this free of any path from deq_D.
   assign allowin_D = (count_w <= ALLOW_MAX);

   // ---------------------------------------------------------------- enqueue
   always_comb begin
      slot0_e = '{pc: pc_F, instr: instr_F[31:0], exc: exc_code_F, tre: tre_F,
                  bp: bp_info_F[0 +: BP_W]};
      slot1_e = '{pc: {pc_F[31:3], 1'b1, pc_F[1:0]}, instr: instr_F[63:32],
                  exc: exc_code_F, tre: tre_F, bp: bp_info_F[BP_W +: BP_W]};
      // in_a is the oldest incoming instruction; a slot1-only pattern moves
      // slot1 into the first write position.
      in_a     = valid_F[0] ? slot0_e : slot1_e;
      in_b     = slot1_e;
      enq_num  = {1'b0, valid_F[0]} + {1'b0, valid_F[1]};
      enq_fire = allowin_D && !flush && (|valid_F);
      wr0_en   = enq_fire;
      wr1_en   = enq_fire && (enq_num == 2'd2);
      wr_idx0  = tail_q[AW-1:0];
      wr_idx1  = wr_idx0 + AW'(1);
   end

   // ------------------------------------------------------ pointer next-state
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      if (flush) begin
         head_d = '0;
         tail_d = '0;
      end else begin
         head_d = head_q + PW'(deq_D);
         if (enq_fire) begin
            tail_d = tail_q + PW'(enq_num);
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head_q <= '0;
         tail_q <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

   // Entry storage is intentionally not reset; pointers define what is live.
   always_ff @(posedge clk) begin
      if (wr0_en) mem_q[wr_idx0] <= in_a;
      if (wr1_en) mem_q[wr_idx1] <= in_b;
   end

   // ---------------------------------------------------------- presentation
   always_comb begin
      rd_idx0 = head_q[AW-1:0];
      rd_idx1 = rd_idx0 + AW'(1);
      rd0     = mem_q[rd_idx0];
      rd1     = mem_q[rd_idx1];
      v0      = (count_w != '0);
      v1      = (count_w >= PW'(2));
      view0   = rd0;
      view1   = rd1;
`ifdef FIQ_BYPASS_EN
      // Forward incoming instructions past empty storage slots. enq_fire
      // already excludes flush cycles.
      if (enq_fire && (count_w == '0)) begin
         v0    = 1'b1;
         v1    = (enq_num == 2'd2);
         view0 = in_a;
         view1 = in_b;
      end else if (enq_fire && (count_w == PW'(1))) begin
         v1    = 1'b1;
         view1 = in_a;
      end
`endif
   end

   always_comb begin
      valid_D    = {v1, v0};
      instr_D    = '0;
      pc_D       = '0;
      exc_code_D = '0;
      tre_D      = '0;
      bp_info_D  = '0;
      if (v0) begin
         instr_D[31:0]         = view0.instr;
         pc_D[31:0]            = view0.pc;
         exc_code_D[4:0]       = view0.exc;
         tre_D[0]              = view0.tre;
         bp_info_D[0 +: BP_W]  = view0.bp;
      end
      if (v1) begin
         instr_D[63:32]          = view1.instr;
         pc_D[63:32]             = view1.pc;
         exc_code_D[9:5]         = view1.exc;
         tre_D[1]                = view1.tre;
         bp_info_D[BP_W +: BP_W] = view1.bp;
      end
   end

   // F must not present instructions while the queue refuses a pair.
   a_no_push_without_allowin: assert property (
      @(posedge clk) disable iff (!resetn) (|valid_F) |-> allowin_D);

endmodule
